// File: rtl/data_memory_sync_pkg.sv
// Shared definitions for the synchronous data memory: FSM encodings,
// response flag bundle and a constant-width helper.
package data_memory_sync_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic valid;
    logic err;
    logic rd_ok;
  } rsp_flags_t;

  // Ceiling log2, used for constant width calculations only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_memory_sync_if.sv
// Request/response bus between the load/store unit (master) and the memory (slave).
interface data_memory_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [BE_W-1:0]       req_be;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  init_busy;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/data_memory_sync_mem_array.sv
// Single-port DEPTH x DATA_WIDTH storage with per-byte write enables and
// a registered read port.
module data_memory_sync_mem_array
  import data_memory_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int IDX_W      = clog2(DEPTH),
  parameter int BE_W       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic [BE_W-1:0]       we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_sync.sv
// Synchronous data memory: post-reset zero fill, then one valid/ready request
// per cycle with a single-cycle response, byte-enable writes and range/alignment checks.
module data_memory_sync
  import data_memory_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int BYTE_ADDR  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  data_memory_sync_if.slave bus
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = clog2(BE_W);
  localparam int IDX_W = clog2(DEPTH);
  localparam int SHIFT = (BYTE_ADDR != 0) ? OFF_W : 0;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << SHIFT) - 1);

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  rsp_flags_t            rsp_q, rsp_d;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  req_err;
  logic                  accept;

  logic [BE_W-1:0]       arr_we;
  logic [IDX_W-1:0]      arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  arr_re;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Any nonzero bit above the index range makes the request out of range.
  assign word_addr = bus.req_addr >> SHIFT;
  assign req_err   = ((bus.req_addr & OFF_MASK) != '0) || (word_addr >= ADDR_WIDTH'(DEPTH));
  assign accept    = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = '0;
    arr_addr  = word_addr[IDX_W-1:0];
    arr_wdata = bus.req_wdata;
    arr_re    = 1'b0;
    if (state_q == ST_INIT) begin
      arr_we    = '1;
      arr_addr  = cnt_q;
      arr_wdata = '0;
      cnt_d     = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
    end else if (accept && !req_err) begin
      if (bus.req_we) arr_we = bus.req_be;
      else            arr_re = 1'b1;
    end
  end

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = accept;
    rsp_d.err   = accept && req_err;
    rsp_d.rd_ok = accept && !req_err && !bus.req_we;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  data_memory_sync_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W),
    .BE_W       (BE_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .rdata_o (arr_rdata)
  );

  assign bus.req_ready = (state_q == ST_RUN);
  assign bus.init_busy = (state_q == ST_INIT);
  assign bus.rsp_valid = rsp_q.valid;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.rsp_rdata = rsp_q.rd_ok ? arr_rdata : '0;

endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync: stimulus pushes expected responses,
// a negedge monitor pops and compares every rsp_valid pulse.
module tb_data_memory_sync;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory_sync #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .BYTE_ADDR  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   rsp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always begin
    @(negedge clk);
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual rdata=%h err=%0b required=none", bus.rsp_rdata, bus.rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_rdata"}, bus.rsp_rdata, mon_e.rdata);
        check({mon_e.name, "_err"}, {31'b0, bus.rsp_err}, {31'b0, mon_e.err});
        $display("RSP %s rdata=%h err=%0b", mon_e.name, bus.rsp_rdata, bus.rsp_err);
      end
    end
  end

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = 4'h0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  // Drive one request for a single edge; req_valid stays high for streaming.
  task automatic issue(input string name, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err, name: name});
    @(posedge clk);
    #1;
    check({name, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic wait_init(input string name);
    int cycles;
    int bad_ready;
    cycles    = 0;
    bad_ready = 0;
    while (bus.init_busy === 1'b1 && cycles < DEPTH + 20) begin
      if (bus.req_ready !== 1'b0) bad_ready++;
      @(posedge clk);
      #1;
      cycles++;
    end
    check({name, "_cycles"}, cycles, DEPTH);
    check({name, "_ready_low_while_busy"}, bad_ready, 0);
    check({name, "_ready_after"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  logic [31:0] stream_data [4];
  int          base_cnt;

  initial begin
    stream_data[0] = 32'h01234567;
    stream_data[1] = 32'h89ABCDEF;
    stream_data[2] = 32'hFFFF0000;
    stream_data[3] = 32'h0000FFFF;
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check("rst_init_busy", {31'b0, bus.init_busy}, 32'd1);

    // Test 1: zero fill; a request held during INIT must not be answered.
    rst_n         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    wait_init("init1");
    idle();
    issue("t1_rd_0x10", 1'b0, 4'h0, 32'h10, 32'h0, 32'h0, 1'b0);

    // Tests 2/3: full write, readback, partial byte-enable merge, be=0 no-op.
    issue("t2_wr_0x40", 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0);
    issue("t2_rd_0x40", 1'b0, 4'h0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
    issue("t3_wr_be5",  1'b1, 4'h5, 32'h40, 32'h11223344, 32'h0, 1'b0);
    issue("t3_rd_0x40", 1'b0, 4'hF, 32'h40, 32'h0, 32'hDE22BE44, 1'b0);
    issue("t3_wr_be0",  1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b0);
    issue("t3_rd_be0",  1'b0, 4'h0, 32'h40, 32'h0, 32'hDE22BE44, 1'b0);

    // Test 4: errors leave memory untouched.
    issue("t4_rd_mis",   1'b0, 4'h0, 32'h42, 32'h0, 32'h0, 1'b1);
    issue("t4_wr_oor",   1'b1, 4'hF, 32'(4 * DEPTH), 32'hCAFEF00D, 32'h0, 1'b1);
    issue("t4_wr_mis",   1'b1, 4'hF, 32'h41, 32'h55555555, 32'h0, 1'b1);
    issue("t4_rd_hi",    1'b0, 4'h0, 32'h80000040, 32'h0, 32'h0, 1'b1);
    issue("t4_rd_0x40",  1'b0, 4'h0, 32'h40, 32'h0, 32'hDE22BE44, 1'b0);
    issue("t4_rd_0x00",  1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    idle();
    @(posedge clk);
    #1;

    // Test 5: eight back-to-back alternating write/read requests.
    base_cnt = rsp_cnt;
    for (int k = 0; k < 4; k++) begin
      issue($sformatf("t5_wr%0d", k), 1'b1, 4'hF, 32'h80 + 32'(4 * k), stream_data[k], 32'h0, 1'b0);
      issue($sformatf("t5_rd%0d", k), 1'b0, 4'h0, 32'h80 + 32'(4 * k), 32'h0, stream_data[k], 1'b0);
    end
    idle();
    @(posedge clk);
    #1;
    check("t5_rsp_count", rsp_cnt - base_cnt, 8);

    // Test 6: reset right after a read is accepted.
    issue("t6_rd_0x40", 1'b0, 4'h0, 32'h40, 32'h0, 32'hDE22BE44, 1'b0);
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    check("t6_rsp_valid_after_rst", {31'b0, bus.rsp_valid}, 32'd0);
    check("t6_init_busy_after_rst", {31'b0, bus.init_busy}, 32'd1);
    check("t6_req_ready_after_rst", {31'b0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    wait_init("init2");
    idle();
    issue("t6_rd_cleared", 1'b0, 4'h0, 32'h40, 32'h0, 32'h0, 1'b0);
    idle();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
